mac_accum_stage: RTL and testbench
==================================

Name: mac_accum_stage

Overview:
- Downstream consumer of the 16-bit pipelined multiplier: accepts the 36-bit product stream and accumulates it into per-frame dot-product results.
- Tracks which multiplier pipeline slots hold real data by delaying the upstream operand-valid/last flags by the multiplier latency, so the multiplier itself needs no valid logic.
- Buffers up to two completed frame results behind a valid/ready output handshake, and throttles operand issue through in_ready so that no result is ever lost.

Parameters:
- LAT, 3, multiplier latency in cycles; operands issued in cycle t produce prod in cycle t+LAT.
- PROD_W, 36, product width.
- ACC_W, 44, accumulator/result width; must be >= PROD_W.
- CNT_W, 8, width of the per-frame sample counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  an operand pair is presented to the multiplier this cycle.
- in_last  in  1  that pair is the last of its frame; ignored unless in_valid=1.
- in_ready  out  1  stage can accept an operand pair this cycle.
- prod  in  PROD_W  multiplier output, unsigned.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer accepts the head result.
- out_acc  out  ACC_W  frame sum, saturated.
- out_count  out  CNT_W  number of samples in the frame, saturated at 2^CNT_W-1.
- out_ovf  out  1  frame sum saturated.

Behaviour:
- Reset (reset=0, asynchronous): delay line, accumulator, counter, ovf flag and FIFO are cleared. Outputs during reset: out_valid=0, out_acc=0, out_count=0, out_ovf=0, in_ready=1. A reset mid-frame discards the partial frame and all in-flight slots.
- Accepted issue: acc_in = in_valid & in_ready. Issues with in_ready=0 are dropped; their products are never counted.
- Delay line: LAT-stage shift register of {vld, last}. Stage 0 loads {acc_in, acc_in & in_last}. The stage-LAT output {d_vld, d_last} is aligned with prod.
- Accumulator FSM:
  - States: IDLE (accumulator holds 0, no frame open) and RUN (frame open).
  - On d_vld: sum = (IDLE ? 0 : acc) + zero-extended prod, evaluated ACC_W+1 bits wide.
  - If bit ACC_W of sum is set, or ovf is already set: acc_next = all ones and ovf_next = 1. Once saturated, the value stays saturated for the rest of the frame.
  - cnt_next = min(cnt+1, 2^CNT_W-1).
  - d_vld & !d_last: go to or stay in RUN with the updated acc/cnt/ovf.
  - d_vld & d_last: push {acc_next, cnt_next, ovf_next} into the FIFO. Clear acc, cnt and ovf, and go to IDLE. A single-sample frame (last on the first sample) is legal.
  - !d_vld: state holds; prod is ignored.
- Result FIFO:
  - Depth 2.
  - out_* show the head entry when out_valid=1 and hold stable until popped; they read 0 when empty.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle are legal in every occupancy state, including full.
- Flow control:
  - in_ready = (fifo_count + number of set last bits in the delay line) < 2, computed from registered state only.
  - This guarantees a free FIFO slot for every last that has been issued. Push when full without a simultaneous pop is unreachable; the implementation asserts this in simulation.
  - in_ready never depends combinationally on out_ready.
- Latency: a last accepted in cycle t gives out_valid=1 in cycle t+LAT+1 when the FIFO was empty.
- Ordering: results leave the FIFO strictly in frame order.

Decomposition:
- Shared package: LAT, PROD_W, ACC_W and CNT_W defaults, the accumulator state encoding (IDLE=0, RUN=1), and the result-entry typedef {acc, count, ovf}.
- One sub-module is natural: result_fifo2, a 2-entry synchronous FIFO with async active-low reset that exposes count, full and empty.
- The delay line and the accumulator stay in the top module.

Test Plan:
- Bench models the multiplier as a LAT-cycle A*B pipe.
- Basic frame: issue pairs (2,3), (5,2), (3,5) in consecutive cycles, with last on the third, out_ready=1 -> one result with out_acc=31, out_count=3, out_ovf=0, appearing LAT+1 cycles after the last issue.
- Overflow: ACC_W=33; issue three pairs (65535,65535), last on the third -> out_acc=0x1FFFFFFFF, out_ovf=1, out_count=3. The next frame, a single pair (1,1), gives out_acc=1, out_ovf=0.
- Count saturation: issue 300 pairs (1,1), last on #300 -> out_acc=300, out_count=255.
- Backpressure: out_ready=0; issue three single-pair frames (1,1), (2,2), (3,3) back-to-back.
  - in_ready drops the cycle after the second last is accepted, so the third is held.
  - Release out_ready -> results 1, 4, 9 in order, nothing lost.
  - The third frame is accepted once in_ready returns to 1.
- Dropped issue: drive in_valid with in_ready=0 carrying pair (7,7) -> no effect on any result.
- Reset mid-frame: issue two pairs (4,4), assert reset for 1 cycle, then issue frame (1,2) with last -> out_acc=2, out_count=1. During reset out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/mac_accum_stage_pkg.sv
// Shared definitions for the multiplier accumulate stage: default parameters,
// the accumulator state encoding and the result-entry layout at default widths.
package mac_accum_stage_pkg;

  localparam int unsigned DefLat   = 3;   // multiplier latency in cycles
  localparam int unsigned DefProdW = 36;  // product width
  localparam int unsigned DefAccW  = 44;  // accumulator / result width
  localparam int unsigned DefCntW  = 8;   // per-frame sample counter width

  typedef enum logic [0:0] {
    StIdle = 1'b0,  // accumulator holds 0, no frame open
    StRun  = 1'b1   // frame open
  } acc_state_e;

  // Result entry at the default widths; the top builds the same layout from
  // its own parameters so that non-default instances stay consistent.
  typedef struct packed {
    logic [DefAccW-1:0] acc;
    logic [DefCntW-1:0] count;
    logic               ovf;
  } result_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry synchronous FIFO with asynchronous active-low reset.
// Ports:
//   clk, reset      clock and async active-low reset
//   push, wdata     write request and data
//   pop, rdata      read request and head data (reads 0 when empty)
//   count           occupancy 0..2
//   full, empty     occupancy flags
// Push and pop in the same cycle are accepted at every occupancy; when full the
// simultaneous pop frees the slot the push lands in.
module result_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/mac_accum_stage.sv
// Accumulate stage behind a LAT-cycle pipelined multiplier.
// Ports:
//   clk, reset           clock and async active-low reset
//   in_valid, in_last    operand pair issued to the multiplier / last of frame
//   in_ready             stage can accept an operand pair this cycle
//   prod                 multiplier output, aligned LAT cycles after issue
//   out_valid, out_ready result handshake
//   out_acc              saturated frame sum
//   out_count            saturated sample count
//   out_ovf              frame sum saturated
// A {vld, last} delay line tracks which multiplier slots carry real data, so the
// multiplier needs no valid logic. Completed frames go to a 2-entry FIFO.
module mac_accum_stage
  import mac_accum_stage_pkg::*;
#(
  parameter int unsigned LAT    = DefLat,
  parameter int unsigned PROD_W = DefProdW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_ovf
);

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } entry_t;

  // Wide enough for fifo_count (<= 2) plus every delay-line stage holding a last.
  localparam int unsigned PendW = $clog2(LAT + 3);

  logic             acc_in;
  logic [LAT-1:0]   vld_q;
  logic [LAT-1:0]   last_q;
  logic             d_vld;
  logic             d_last;

  acc_state_e       state_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   sum;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ovf_q;
  logic             ovf_nxt;

  logic             push;
  logic             pop;
  entry_t           push_data;
  entry_t           head;
  logic [1:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PendW-1:0] pending;

  // Every issued last owns a future FIFO slot, so stop issuing once two are
  // committed (queued or still in flight). Registered state only.
  always_comb begin
    pending = PendW'(fifo_count);
    for (int i = 0; i < LAT; i++) begin
      pending = pending + PendW'(last_q[i]);
    end
    in_ready = (pending < PendW'(2));
  end

  assign acc_in = in_valid & in_ready;
  assign d_vld  = vld_q[LAT-1];
  assign d_last = last_q[LAT-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      last_q <= '0;
    end else begin
      vld_q[0]  <= acc_in;
      last_q[0] <= acc_in & in_last;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
    end
  end

  // One extra bit catches the carry out; once saturated the frame stays saturated.
  always_comb begin
    acc_base = (state_q == StRun) ? acc_q : '0;
    sum      = {1'b0, acc_base} + (ACC_W + 1)'(prod);
    ovf_nxt  = sum[ACC_W] | ovf_q;
    acc_nxt  = ovf_nxt ? '1 : sum[ACC_W-1:0];
    cnt_nxt  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (d_vld) begin
      if (d_last) begin
        state_q <= StIdle;
        acc_q   <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= StRun;
        acc_q   <= acc_nxt;
        cnt_q   <= cnt_nxt;
        ovf_q   <= ovf_nxt;
      end
    end
  end

  assign push            = d_vld & d_last;
  assign push_data.acc   = acc_nxt;
  assign push_data.count = cnt_nxt;
  assign push_data.ovf   = ovf_nxt;
  assign pop             = out_valid & out_ready;

  result_fifo2 #(
    .W($bits(entry_t))
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .wdata(push_data),
    .pop  (pop),
    .rdata(head),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_acc   = head.acc;
  assign out_count = head.count;
  assign out_ovf   = head.ovf;

  // Flow control makes a push into a full FIFO without a pop unreachable.
  push_full_a : assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_mac_accum_stage.sv
module tb_mac_accum_stage;

  localparam int unsigned LAT    = 3;
  localparam int unsigned PROD_W = 36;
  localparam int unsigned ACC_W  = 44;
  localparam int unsigned CNT_W  = 8;
  localparam longint unsigned ACC_MAX = (64'd1 << ACC_W) - 64'd1;

  typedef struct {
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  // Main DUT (default widths)
  logic              in_valid = 1'b0, in_last = 1'b0, in_ready;
  logic [15:0]       in_a = '0, in_b = '0;
  logic [PROD_W-1:0] prod;
  logic              out_valid, out_ready = 1'b1;
  logic [ACC_W-1:0]  out_acc;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Narrow-accumulator DUT for the saturation case
  logic        o_valid = 1'b0, o_last = 1'b0, o_in_ready;
  logic [15:0] o_a = '0, o_b = '0;
  logic [31:0] o_prod;
  logic        o_out_valid, o_out_ready = 1'b1;
  logic [32:0] o_acc;
  logic [7:0]  o_cnt;
  logic        o_ovf;

  int total = 0;
  int bad = 0;
  bit rand_rdy = 1'b0;

  // Reference model state
  longint unsigned  f_sum = 0;
  int               f_cnt = 0;
  int               outstanding = 0;
  exp_t             exp_q[$];
  logic [ACC_W-1:0] got_log[$];

  always #5 clk = ~clk;

  mac_accum_stage #(
    .LAT(LAT), .PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  mac_accum_stage #(
    .LAT(LAT), .PROD_W(32), .ACC_W(33), .CNT_W(8)
  ) u_ovf (
    .clk(clk), .reset(reset), .in_valid(o_valid), .in_last(o_last), .in_ready(o_in_ready),
    .prod(o_prod), .out_valid(o_out_valid), .out_ready(o_out_ready), .out_acc(o_acc),
    .out_count(o_cnt), .out_ovf(o_ovf)
  );

  // Multiplier models: LAT-cycle A*B pipes, no valid logic.
  logic [PROD_W-1:0] mpipe[LAT];
  logic [31:0]       opipe[LAT];
  always @(posedge clk) begin
    mpipe[0] <= PROD_W'(in_a) * PROD_W'(in_b);
    opipe[0] <= 32'(o_a) * 32'(o_b);
    for (int i = 1; i < LAT; i++) begin
      mpipe[i] <= mpipe[i-1];
      opipe[i] <= opipe[i-1];
    end
  end
  assign prod   = mpipe[LAT-1];
  assign o_prod = opipe[LAT-1];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Scoreboard: frame sums from accepted issues, results in frame order,
  // and in_ready from the number of accepted lasts not yet popped.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        f_sum = 0;
        f_cnt = 0;
        outstanding = 0;
        exp_q.delete();
      end else begin
        check("in_ready", 64'(in_ready), 64'(outstanding < 2));
        if (!out_valid) check("empty_outputs", {out_acc, out_count, out_ovf}, 64'd0);
        if (in_valid && in_ready) begin
          f_sum += longint'(in_a) * longint'(in_b);
          f_cnt++;
          if (in_last) begin
            exp_t e;
            e.acc = ACC_W'((f_sum > ACC_MAX) ? ACC_MAX : f_sum);
            e.cnt = (f_cnt > 255) ? 8'd255 : 8'(f_cnt);
            e.ovf = (f_sum > ACC_MAX);
            exp_q.push_back(e);
            f_sum = 0;
            f_cnt = 0;
            outstanding++;
          end
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("res_acc", 64'(out_acc), 64'(e.acc));
            check("res_count", 64'(out_count), 64'(e.cnt));
            check("res_ovf", 64'(out_ovf), 64'(e.ovf));
          end
          got_log.push_back(out_acc);
          outstanding--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present a pair and hold it until accepted. Called just after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input bit last);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    for (int g = 0; g < 500; g++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok = 1'b0;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_o();
    bit ok = 1'b0;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      if (o_out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("ovf_dut_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[6];
    int   base;
    bit   ok;

    tbl[0] = '{16'd0,     16'd9,     44'd0,          8'd1, 1'b0};
    tbl[1] = '{16'd1,     16'd1,     44'd1,          8'd1, 1'b0};
    tbl[2] = '{16'd65535, 16'd65535, 44'hFFFE0001,   8'd1, 1'b0};
    tbl[3] = '{16'd255,   16'd256,   44'd65280,      8'd1, 1'b0};
    tbl[4] = '{16'd12345, 16'd2,     44'd24690,      8'd1, 1'b0};
    tbl[5] = '{16'd40000, 16'd3,     44'd120000,     8'd1, 1'b0};

    // Reset state
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outputs", {out_acc, out_count, out_ovf}, 64'd0);
    check("rst_o_out_valid", 64'(o_out_valid), 64'd0);
    check("rst_o_in_ready", 64'(o_in_ready), 64'd1);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic frame and first-result latency
    send(16'd2, 16'd3, 1'b0);
    send(16'd5, 16'd2, 1'b0);
    send(16'd3, 16'd5, 1'b1);
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      check("lat_early_valid", 64'(out_valid), 64'd0);
      tick();
    end
    @(negedge clk);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("basic_acc", 64'(out_acc), 64'd31);
    check("basic_count", 64'(out_count), 64'd3);
    check("basic_ovf", 64'(out_ovf), 64'd0);
    tick();

    // Single-sample frames from the table
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].a, tbl[i].b, 1'b1);
      wait_out("tbl_wait");
      check("tbl_acc", 64'(out_acc), 64'(tbl[i].acc));
      check("tbl_count", 64'(out_count), 64'(tbl[i].cnt));
      check("tbl_ovf", 64'(out_ovf), 64'(tbl[i].ovf));
      tick();
    end

    // Count saturation
    for (int i = 1; i <= 300; i++) send(16'd1, 16'd1, i == 300);
    wait_out("cnt_wait");
    check("cnt_sat_acc", 64'(out_acc), 64'd300);
    check("cnt_sat_count", 64'(out_count), 64'd255);
    check("cnt_sat_ovf", 64'(out_ovf), 64'd0);
    tick();

    // Backpressure with a dropped issue while in_ready is low
    out_ready = 1'b0;
    base = got_log.size();
    send(16'd1, 16'd1, 1'b1);
    send(16'd2, 16'd2, 1'b1);
    @(negedge clk);
    check("bp_in_ready_drop", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b1;
    in_a = 16'd7;
    in_b = 16'd7;
    in_last = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("drop_in_ready", 64'(in_ready), 64'd0);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_head_valid", 64'(out_valid), 64'd1);
    check("bp_head_stable", 64'(out_acc), 64'd1);
    tick();
    out_ready = 1'b1;
    send(16'd3, 16'd3, 1'b1);
    ok = 1'b0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (got_log.size() >= base + 3) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("bp_results_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("bp_order0", 64'(got_log[base]), 64'd1);
      check("bp_order1", 64'(got_log[base+1]), 64'd4);
      check("bp_order2", 64'(got_log[base+2]), 64'd9);
    end
    tick();

    // Reset mid-frame: one sample in the accumulator, one still in flight
    send(16'd4, 16'd4, 1'b0);
    send(16'd4, 16'd4, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    tick();
    reset = 1'b1;
    send(16'd1, 16'd2, 1'b1);
    wait_out("midrst_wait");
    check("midrst_acc", 64'(out_acc), 64'd2);
    check("midrst_count", 64'(out_count), 64'd1);
    check("midrst_ovf", 64'(out_ovf), 64'd0);
    tick();

    // Saturation on the 33-bit instance, then a clean frame
    o_valid = 1'b1;
    o_a = 16'd65535;
    o_b = 16'd65535;
    o_last = 1'b0;
    tick();
    tick();
    o_last = 1'b1;
    tick();
    o_valid = 1'b0;
    o_last = 1'b0;
    wait_o();
    check("sat_acc", 64'(o_acc), 64'h1FFFFFFFF);
    check("sat_count", 64'(o_cnt), 64'd3);
    check("sat_ovf", 64'(o_ovf), 64'd1);
    tick();
    o_valid = 1'b1;
    o_a = 16'd1;
    o_b = 16'd1;
    o_last = 1'b1;
    tick();
    o_valid = 1'b0;
    o_last = 1'b0;
    wait_o();
    check("post_sat_acc", 64'(o_acc), 64'd1);
    check("post_sat_count", 64'(o_cnt), 64'd1);
    check("post_sat_ovf", 64'(o_ovf), 64'd0);
    tick();

    // Random frames with random consumer stalls
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int s = 0; s < len; s++) begin
        send(16'($urandom), 16'($urandom), s == len - 1);
        if ($urandom_range(0, 3) == 0) tick();
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && outstanding == 0) break;
      tick();
    end
    check("drain_results", 64'(exp_q.size()), 64'd0);
    check("drain_outstanding", 64'(outstanding), 64'd0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
